eth_pkt_if_to_avalon_st_adapter: RTL and testbench

Converts the internal 64-bit `eth_pkt_if` packet stream into an Avalon-ST source for Avalon-ST sinks such as MAC TX or FIFO IP. It also enforces packet framing: beats outside a packet are dropped, and a packet missing its `eop` is closed with a synthetic error beat. It sits between the packet-generation/processing path and any Avalon-ST consumer, and is buffered so that every output is registered.

---
 rtl/eth_pkt_if.sv | 14 +
 rtl/eth_pkt_if_to_avalon_st_adapter.sv | 188 ++++++++++++++++++
 tb/tb_eth_pkt_if_to_avalon_st_adapter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkt_if.sv
// Internal 64-bit packet stream. The producer drives data/framing/val and the
// consumer returns ready. mod is the count of valid bytes on the eop beat,
// with 0 meaning all eight bytes are valid.
interface eth_pkt_if;
  logic [63:0] data;
  logic        val;
  logic        sop;
  logic        eop;
  logic [2:0]  mod;
  logic        ready;

  modport i (input data, val, sop, eop, mod, output ready);
  modport o (output data, val, sop, eop, mod, input ready);
endinterface

// File: rtl/eth_pkt_if_to_avalon_st_adapter.sv
// eth_pkt_if -> Avalon-ST source adapter with framing enforcement.
// Orphan beats (outside a packet) are dropped and counted. A packet that is cut
// short by a new sop is closed with a synthetic error/eop beat and counted.
// Beats are buffered in a 4-entry shift FIFO. Slot 0 is the Avalon head, so
// every st_* output comes straight from a flop.
module eth_pkt_if_to_avalon_st_adapter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  eth_pkt_if.i             pkt_i,
  output logic [63:0]      st_data,
  output logic             st_valid,
  output logic             st_startofpacket,
  output logic             st_endofpacket,
  output logic [2:0]       st_empty,
  output logic             st_error,
  input  logic             st_ready,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] orphan_cnt_o,
  output logic [CNT_W-1:0] trunc_cnt_o
);

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        error;
  } beat_t;

  typedef enum logic {
    S_IDLE,
    S_IN_PKT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state_q, state_d;
  beat_t      fifo_q [4];
  beat_t      fifo_d [4];
  logic [2:0] count_q, count_d;
  logic       valid_q;
  logic       ready_q;
  logic [CNT_W-1:0] orphan_q, orphan_d;
  logic [CNT_W-1:0] trunc_q, trunc_d;

  logic       accept;
  logic       pop;
  logic [2:0] base;
  logic [1:0] push_n;
  beat_t      push0, push1;
  beat_t      real_beat;
  logic       orphan_inc;
  logic       trunc_inc;

  assign accept = pkt_i.val && ready_q;
  assign pop    = valid_q && st_ready;

  // Convert the incoming beat into its Avalon form (mod -> empty, error clear).
  // NOTE: every always_comb output gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    real_beat       = '0;
    real_beat.data  = pkt_i.data;
    real_beat.sop   = pkt_i.sop;
    real_beat.eop   = pkt_i.eop;
    real_beat.error = 1'b0;
    if (pkt_i.eop) begin
      real_beat.empty = (pkt_i.mod == 3'd0) ? 3'd0 : 3'(4'd8 - {1'b0, pkt_i.mod});
    end
  end

  // Framing FSM state register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Framing FSM next state; only accepted beats move it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        S_IDLE:   if (pkt_i.sop) state_d = pkt_i.eop ? S_IDLE : S_IN_PKT;
        S_IN_PKT: state_d = pkt_i.eop ? S_IDLE : S_IN_PKT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Framing FSM outputs: which entries to push and which counter to bump.
  always_comb begin
    push_n     = 2'd0;
    push0      = real_beat;
    push1      = real_beat;
    orphan_inc = 1'b0;
    trunc_inc  = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (pkt_i.sop) push_n = 2'd1;
          else           orphan_inc = 1'b1;
        end
        S_IN_PKT: begin
          if (pkt_i.sop) begin
            // Close the open packet before the new one starts.
            push_n      = 2'd2;
            push0       = '0;
            push0.eop   = 1'b1;
            push0.error = 1'b1;
            trunc_inc   = 1'b1;
          end else begin
            push_n = 2'd1;
          end
        end
        default: push_n = 2'd0;
      endcase
    end
  end

  // Shift FIFO next state: pop shifts toward the head, pushes land above the
  // remaining entries. ready guarantees two free slots, so base+1 never exceeds 3.
  always_comb begin
    fifo_d = fifo_q;
    if (pop) begin
      for (int i = 0; i < 3; i++) fifo_d[i] = fifo_q[i+1];
    end
    base = count_q - {2'b00, pop};
    if (push_n != 2'd0) fifo_d[base[1:0]] = push0;
    if (push_n == 2'd2) fifo_d[base[1:0] + 2'd1] = push1;
    count_d = base + {1'b0, push_n};
  end

  // FIFO storage, occupancy, registered valid and registered ready.
  // NOTE: the storage is reset (only four entries) because slot 0 drives the
  // Avalon outputs directly and they must read zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      count_q <= 3'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      count_q <= count_d;
      valid_q <= (count_d != 3'd0);
      ready_q <= (count_d <= 3'd2);
    end
  end

  // Saturating framing-error counters; clear wins over increment.
  always_comb begin
    orphan_d = orphan_q;
    trunc_d  = trunc_q;
    if (cnt_clr_i) begin
      orphan_d = '0;
      trunc_d  = '0;
    end else begin
      if (orphan_inc && orphan_q != CNT_MAX) orphan_d = orphan_q + 1'b1;
      if (trunc_inc && trunc_q != CNT_MAX)   trunc_d  = trunc_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      orphan_q <= '0;
      trunc_q  <= '0;
    end else begin
      orphan_q <= orphan_d;
      trunc_q  <= trunc_d;
    end
  end

  assign pkt_i.ready      = ready_q;
  assign st_valid         = valid_q;
  assign st_data          = fifo_q[0].data;
  assign st_startofpacket = fifo_q[0].sop;
  assign st_endofpacket   = fifo_q[0].eop;
  assign st_empty         = fifo_q[0].empty;
  assign st_error         = fifo_q[0].error;
  assign orphan_cnt_o     = orphan_q;
  assign trunc_cnt_o      = trunc_q;

endmodule

// File: tb/tb_eth_pkt_if_to_avalon_st_adapter.sv
// Directed bench for eth_pkt_if_to_avalon_st_adapter. The DUT is built with
// 2-bit counters so saturation is reachable with a handful of beats.
module tb_eth_pkt_if_to_avalon_st_adapter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      st_data;
  logic             st_valid;
  logic             st_sop;
  logic             st_eop;
  logic [2:0]       st_empty;
  logic             st_error;
  logic             st_ready;
  logic             cnt_clr;
  logic [CNT_W-1:0] orphan_cnt;
  logic [CNT_W-1:0] trunc_cnt;

  int n_checks = 0;
  int n_err    = 0;

  eth_pkt_if pkt ();

  eth_pkt_if_to_avalon_st_adapter #(.CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pkt_i            (pkt),
    .st_data          (st_data),
    .st_valid         (st_valid),
    .st_startofpacket (st_sop),
    .st_endofpacket   (st_eop),
    .st_empty         (st_empty),
    .st_error         (st_error),
    .st_ready         (st_ready),
    .cnt_clr_i        (cnt_clr),
    .orphan_cnt_o     (orphan_cnt),
    .trunc_cnt_o      (trunc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the whole Avalon head against an expected valid beat.
  task automatic check_beat(input string tag, input logic [63:0] data, input logic sop,
                            input logic eop, input logic [2:0] empty, input logic err);
    check({tag, ".valid"}, 64'(st_valid), 64'd1);
    check({tag, ".data"},  st_data,       data);
    check({tag, ".sop"},   64'(st_sop),   64'(sop));
    check({tag, ".eop"},   64'(st_eop),   64'(eop));
    check({tag, ".empty"}, 64'(st_empty), 64'(empty));
    check({tag, ".error"}, 64'(st_error), 64'(err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] data, input logic sop, input logic eop,
                       input logic [2:0] mod);
    pkt.val  = 1'b1;
    pkt.data = data;
    pkt.sop  = sop;
    pkt.eop  = eop;
    pkt.mod  = mod;
  endtask

  task automatic idle();
    pkt.val  = 1'b0;
    pkt.data = '0;
    pkt.sop  = 1'b0;
    pkt.eop  = 1'b0;
    pkt.mod  = '0;
  endtask

  initial begin
    rst      = 1'b1;
    st_ready = 1'b0;
    cnt_clr  = 1'b0;
    idle();
    tick();
    tick();

    // Reset state
    check("rst.valid",  64'(st_valid),   64'd0);
    check("rst.data",   st_data,         64'd0);
    check("rst.sop",    64'(st_sop),     64'd0);
    check("rst.eop",    64'(st_eop),     64'd0);
    check("rst.empty",  64'(st_empty),   64'd0);
    check("rst.error",  64'(st_error),   64'd0);
    check("rst.ready",  64'(pkt.ready),  64'd0);
    check("rst.orphan", 64'(orphan_cnt), 64'd0);
    check("rst.trunc",  64'(trunc_cnt),  64'd0);

    rst = 1'b0;
    tick();
    check("post_rst.ready", 64'(pkt.ready), 64'd1);

    // Single 1-beat packet, mod 3 -> empty 5
    st_ready = 1'b1;
    drive(64'h1122_3344_5566_7788, 1'b1, 1'b1, 3'd3);
    tick();
    idle();
    check_beat("one_beat", 64'h1122_3344_5566_7788, 1'b1, 1'b1, 3'd5, 1'b0);
    tick();
    check("one_beat.drained", 64'(st_valid), 64'd0);

    // 4-beat packet with a 5-cycle stall after the first beat is shown
    drive(64'hD000_0000_0000_0000, 1'b1, 1'b0, 3'd0);
    tick();
    check_beat("p4.d0", 64'hD000_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
    st_ready = 1'b0;
    drive(64'hD000_0000_0000_0001, 1'b0, 1'b0, 3'd0);
    tick();
    check("p4.ready_two_held", 64'(pkt.ready), 64'd1);
    drive(64'hD000_0000_0000_0002, 1'b0, 1'b0, 3'd0);
    tick();
    check("p4.ready_three_held", 64'(pkt.ready), 64'd0);
    check_beat("p4.hold1", 64'hD000_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
    drive(64'hD000_0000_0000_0003, 1'b0, 1'b1, 3'd0);
    tick();
    tick();
    tick();
    check("p4.ready_still_low", 64'(pkt.ready), 64'd0);
    check_beat("p4.hold2", 64'hD000_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
    st_ready = 1'b1;
    tick();
    check_beat("p4.d1", 64'hD000_0000_0000_0001, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    idle();
    check_beat("p4.d2", 64'hD000_0000_0000_0002, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    check_beat("p4.d3", 64'hD000_0000_0000_0003, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    check("p4.drained", 64'(st_valid), 64'd0);

    // Orphans in IDLE
    drive(64'hBAD0_0000_0000_0001, 1'b0, 1'b0, 3'd0);
    tick();
    check("orphan1.valid", 64'(st_valid), 64'd0);
    drive(64'hBAD0_0000_0000_0002, 1'b0, 1'b1, 3'd4);
    tick();
    check("orphan2.valid", 64'(st_valid),   64'd0);
    check("orphan2.count", 64'(orphan_cnt), 64'd2);

    // Saturation at 3 with 2-bit counters, then clear racing an increment
    tick();
    tick();
    tick();
    check("orphan5.sat", 64'(orphan_cnt), 64'd3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    idle();
    check("orphan.clr_wins", 64'(orphan_cnt), 64'd0);
    check("orphan.no_valid", 64'(st_valid),   64'd0);

    // Truncation: A(sop), B, C(sop+eop, mod 6)
    drive(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 3'd0);
    tick();
    check_beat("trunc.a", 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 3'd0, 1'b0);
    drive(64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b0, 3'd0);
    tick();
    check_beat("trunc.b", 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b0, 3'd0, 1'b0);
    drive(64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 1'b1, 3'd6);
    tick();
    idle();
    check_beat("trunc.synth", 64'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    check("trunc.count", 64'(trunc_cnt), 64'd1);
    tick();
    check_beat("trunc.c", 64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 1'b1, 3'd2, 1'b0);
    tick();
    check("trunc.drained", 64'(st_valid), 64'd0);

    // Reset mid-packet with two beats buffered
    st_ready = 1'b0;
    drive(64'hEEEE_0000_0000_0000, 1'b1, 1'b0, 3'd0);
    tick();
    drive(64'hEEEE_0000_0000_0001, 1'b0, 1'b0, 3'd0);
    tick();
    idle();
    check_beat("midrst.held", 64'hEEEE_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst.valid", 64'(st_valid),  64'd0);
    check("midrst.data",  st_data,        64'd0);
    check("midrst.trunc", 64'(trunc_cnt), 64'd0);
    rst = 1'b0;
    tick();
    st_ready = 1'b1;
    drive(64'hEEEE_0000_0000_0002, 1'b0, 1'b1, 3'd0);
    tick();
    idle();
    check("midrst.orphan_valid", 64'(st_valid),   64'd0);
    check("midrst.orphan_count", 64'(orphan_cnt), 64'd1);
    tick();
    check("midrst.empty_after", 64'(st_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
